mem_bank_arbiter: RTL and testbench
===================================

Name: mem_bank_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the 32x8 single-port scan-chain memory bank.
- Requester A is the CPU load/store/fetch path; requester B is the debug/loader port.
- Serialises accesses with round-robin fairness and drives the bank's address/data/write_enable.
- Blocks all new accesses while the memory scan chain is active.

Parameters:
ADDR_WIDTH, 5, memory address width (matches bank)
DATA_WIDTH, 8, memory word width (matches bank)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
req_a  input  1  requester A access request; held until gnt_a
we_a  input  1  A: 1 = write, 0 = read; stable while req_a high
addr_a  input  ADDR_WIDTH  A address; stable while req_a high
wdata_a  input  DATA_WIDTH  A write data; stable while req_a high
gnt_a  output  1  one-cycle pulse: A's access is being performed this cycle
ack_a  output  1  one-cycle pulse, cycle after gnt_a: access complete
rdata_a  output  DATA_WIDTH  A read data; valid when ack_a after a read
req_b, we_b, addr_b, wdata_b, gnt_b, ack_b, rdata_b  same as A, for requester B
scan_hold  input  1  1 = scan chain in use; no new grants
mem_address  output  ADDR_WIDTH  to bank address
mem_data_in  output  DATA_WIDTH  to bank data_in
mem_write_enable  output  1  to bank write_enable
mem_data_out  input  DATA_WIDTH  from bank combinational read data
busy  output  1  1 while in ACCESS

Behaviour:
- States: IDLE, ACCESS. Reset (rst==0 at edge) -> IDLE.
- Reset values: gnt_a/b=0, ack_a/b=0, rdata_a/b=0, mem_address=0, mem_data_in=0, busy=0, last-served pointer = B (A wins first tie).
- mem_write_enable = we_reg AND rst, gated combinationally, so it is 0 throughout any reset cycle.
- IDLE:
  - If scan_hold==0 and any req: pick winner.
  - Only one requesting -> that one wins. Both requesting -> the one not served last wins.
  - Register mem_address, mem_data_in, we_reg and owner from the winner.
  - Set gnt_<winner>=1, update last-served pointer, go to ACCESS.
  - If scan_hold==1 or no req: stay in IDLE; outputs hold, we_reg=0.
- ACCESS (exactly 1 cycle):
  - busy=1; gnt_<owner>=1; mem_write_enable=we_reg.
  - The bank write commits at the edge ending ACCESS.
  - At that edge: for a read, rdata_<owner> <= mem_data_out; for a write, rdata unchanged.
  - ack_<owner> <= 1; gnt <= 0; we_reg <= 0; go to IDLE.
- Timing:
  - Request sampled in cycle N -> gnt in N+1 -> ack/rdata in N+2.
  - Maximum throughput: one access per 2 cycles.
  - ack coincides with the next IDLE arbitration cycle.
- Requester rules:
  - Drop req in the cycle after gnt, i.e. the ack cycle.
  - A req still high in the ack cycle is treated as a new request.
- scan_hold:
  - Sampled only in IDLE.
  - Assertion during ACCESS does not abort it; the access completes and ack is still issued.
  - Requests wait indefinitely while scan_hold==1; no requests are dropped.
- mem_address and mem_data_in hold their last granted values between accesses. No glitching back to 0.
- Reset mid-ACCESS: no write reaches the bank, no ack is issued, and the next state is IDLE.
- Address wrap: none; addresses are passed through verbatim, with no range check.

Test Plan:
1. Reset: rst=0 for 2 cycles with req_a=1 -> gnt/ack/mem_write_enable all 0. After rst=1, gnt_a pulses in the next cycle.
2. Single write then read, A: write addr 5 data 0x3C -> gnt_a at N+1 with mem_address=5, mem_data_in=0x3C, mem_write_enable=1; ack_a at N+2. Then read addr 5 -> ack_a with rdata_a=0x3C.
3. Contention: req_a and req_b held high continuously -> grants alternate A,B,A,B, each 2 cycles apart. B read of addr 15 returns the value A wrote there.
4. scan_hold: assert scan_hold=1 while req_b=1 for 10 cycles -> no gnt_b, busy=0. Deassert -> gnt_b in the next cycle and ack_b the cycle after. Raising scan_hold during ACCESS still yields ack.
5. Reset mid-write: A write addr 7 data 0xFF, rst=0 in the ACCESS cycle -> mem_write_enable=0 that cycle, no ack_a, and a later read of addr 7 returns the pre-write value.
6. Write/read isolation: B write addr 2 data 0xA5, then A read addr 2 -> rdata_a=0xA5, and rdata_b stays at its prior value.

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the 32x8 single-port scan-chain bank.
// Each access is one IDLE arbitration cycle followed by one ACCESS cycle; scan_hold blocks new grants.
module mem_bank_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  ack_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  scan_hold,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0] state;
  logic       we_reg;
  logic       owner_b;
  logic       last_b;
  logic       pick_b;
  logic       start;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) pick_b = ~last_b;
  end

  assign start            = (state == IDLE) && !scan_hold && (req_a || req_b);
  assign busy             = (state == ACCESS);
  // Gating with rst keeps a reset landing mid-ACCESS from committing a write.
  assign mem_write_enable = we_reg & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      we_reg      <= 1'b0;
      owner_b     <= 1'b0;
      last_b      <= 1'b1;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mem_address <= pick_b ? addr_b  : addr_a;
          mem_data_in <= pick_b ? wdata_b : wdata_a;
          we_reg      <= pick_b ? we_b    : we_a;
          owner_b     <= pick_b;
          last_b      <= pick_b;
          gnt_a       <= ~pick_b;
          gnt_b       <= pick_b;
          state       <= ACCESS;
        end else begin
          we_reg <= 1'b0;
        end
      end else begin
        // The bank write commits on this edge; a read captures the combinational bank output.
        if (!we_reg) begin
          if (owner_b) rdata_b <= mem_data_out;
          else         rdata_a <= mem_data_out;
        end
        ack_a  <= ~owner_b;
        ack_b  <= owner_b;
        gnt_a  <= 1'b0;
        gnt_b  <= 1'b0;
        we_reg <= 1'b0;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: directed steps plus random transactions, checked against a
// transaction-level model of the bank contents and round-robin order.
module tb_mem_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, gnt_a, ack_a;
  logic [4:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       req_b, we_b, gnt_b, ack_b;
  logic [4:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       scan_hold;
  logic [4:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
  logic       mem_write_enable, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] bank [32];
  logic       bank_init;
  logic [7:0] ref_mem [32];
  logic [7:0] ref_rd_a, ref_rd_b;
  bit         ref_last_b;

  always #5 clk = ~clk;

  mem_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .scan_hold(scan_hold),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  // Behavioural 32x8 bank: combinational read, write on the rising edge.
  assign mem_data_out = bank[mem_address];
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 32; i++) bank[i] <= 8'(i * 7 + 3);
    end else if (mem_write_enable) begin
      bank[mem_address] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One granted access, starting at the negedge before its expected grant cycle.
  task automatic serve(input bit is_b, input bit we, input logic [4:0] addr,
                       input logic [7:0] d, input bit sh);
    @(negedge clk);
    check(is_b ? "gnt_b" : "gnt_a", 32'(is_b ? gnt_b : gnt_a), 32'd1);
    check("gnt_other", 32'(is_b ? gnt_a : gnt_b), 32'd0);
    check("busy_access", 32'(busy), 32'd1);
    check("mem_address", 32'(mem_address), 32'(addr));
    check("mem_write_enable", 32'(mem_write_enable), 32'(we));
    if (we) check("mem_data_in", 32'(mem_data_in), 32'(d));
    if (is_b) req_b = 1'b0; else req_a = 1'b0;
    if (sh) scan_hold = 1'b1;
    if (we) ref_mem[addr] = d;
    else if (is_b) ref_rd_b = ref_mem[addr];
    else ref_rd_a = ref_mem[addr];
    ref_last_b = is_b;
    @(negedge clk);
    check(is_b ? "ack_b" : "ack_a", 32'(is_b ? ack_b : ack_a), 32'd1);
    check("ack_other", 32'(is_b ? ack_a : ack_b), 32'd0);
    check("gnt_in_ack", 32'({gnt_a, gnt_b}), 32'd0);
    check("busy_ack", 32'(busy), 32'd0);
    check("rdata_a", 32'(rdata_a), 32'(ref_rd_a));
    check("rdata_b", 32'(rdata_b), 32'(ref_rd_b));
    if (sh) scan_hold = 1'b0;
  endtask

  // Raise one or both requests together; the model orders them by round-robin.
  task automatic pair(input bit ua, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                      input bit ub, input bit wb, input logic [4:0] ab, input logic [7:0] db);
    req_a = ua; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = ub; we_b = wb; addr_b = ab; wdata_b = db;
    if (ua && ub) begin
      if (ref_last_b) begin
        serve(1'b0, wa, aa, da, 1'b0);
        serve(1'b1, wb, ab, db, 1'b0);
      end else begin
        serve(1'b1, wb, ab, db, 1'b0);
        serve(1'b0, wa, aa, da, 1'b0);
      end
    end else if (ua) begin
      serve(1'b0, wa, aa, da, 1'b0);
    end else begin
      serve(1'b1, wb, ab, db, 1'b0);
    end
  endtask

  initial begin
    bit         ua, ub, wa, wb;
    logic [4:0] ra, rb;
    logic [7:0] dra, drb;
    int         sel;

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_rd_a = 8'h00; ref_rd_b = 8'h00; ref_last_b = 1'b1;
    bank_init = 1'b1;
    rst = 1'b0; scan_hold = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd3; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; addr_b = 5'd0; wdata_b = 8'h00;

    // Reset held with a pending request.
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
      check("rst_ack", 32'({ack_a, ack_b}), 32'd0);
      check("rst_we", 32'(mem_write_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    end
    bank_init = 1'b0;
    rst = 1'b1;
    pair(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // A write then read back.
    pair(1'b1, 1'b1, 5'd5, 8'h3C, 1'b0, 1'b0, 5'd0, 8'h00);
    pair(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // B write, A read; rdata_b must stay put.
    pair(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd2, 8'hA5);
    pair(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // scan_hold raised during ACCESS still completes with an ack.
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd20; wdata_a = 8'h77;
    serve(1'b0, 1'b1, 5'd20, 8'h77, 1'b1);

    // scan_hold blocks a waiting B read for 10 cycles.
    scan_hold = 1'b1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd9;
    repeat (10) begin
      @(negedge clk);
      check("hold_gnt_b", 32'(gnt_b), 32'd0);
      check("hold_busy", 32'(busy), 32'd0);
    end
    scan_hold = 1'b0;
    pair(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd9, 8'h00);

    // Contention: A wins after B, B then reads what A wrote.
    pair(1'b1, 1'b1, 5'd15, 8'h5A, 1'b1, 1'b0, 5'd15, 8'h00);
    pair(1'b1, 1'b0, 5'd15, 8'h00, 1'b1, 1'b1, 5'd16, 8'h11);

    // Reset during a write's ACCESS cycle.
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd7; wdata_a = 8'hFF;
    @(negedge clk);
    check("rw_gnt_a", 32'(gnt_a), 32'd1);
    check("rw_we_before", 32'(mem_write_enable), 32'd1);
    rst = 1'b0; req_a = 1'b0;
    #1;
    check("rw_we_gated", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    check("rw_no_ack", 32'({ack_a, ack_b}), 32'd0);
    check("rw_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_mem_address", 32'(mem_address), 32'd0);
    rst = 1'b1;
    ref_rd_a = 8'h00; ref_rd_b = 8'h00; ref_last_b = 1'b1;
    pair(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // Random single and contended transactions.
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(2, 0));
      ua  = (sel != 1);
      ub  = (sel != 0);
      wa  = 1'($urandom_range(1, 0));
      wb  = 1'($urandom_range(1, 0));
      ra  = 5'($urandom_range(31, 0));
      rb  = ($urandom_range(3, 0) == 0) ? ra : 5'($urandom_range(31, 0));
      dra = 8'($urandom_range(255, 0));
      drb = 8'($urandom_range(255, 0));
      pair(ua, wa, ra, dra, ub, wb, rb, drb);
    end

    @(negedge clk);
    check("final_idle", 32'({busy, gnt_a, gnt_b, ack_a, ack_b}), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
